// File: rtl/mem_arbiter_l1_pkg.sv
// Shared types and constants for the L1 memory-port arbiter.
// Contents: FSM state enum, grant enum, line-offset width and line-align mask.
// Used by mem_arbiter_l1 and rr_arb2 via import mem_arb_pkg::*.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic {
      GNT_I = 1'b0,
      GNT_D = 1'b1
   } grant_e;

   // 32-byte lines: the low LINE_OFF_W address bits select a byte within the line
   localparam int LINE_OFF_W = 5;

   // AND with a byte address to get the line base; slice to the address width in use
   localparam logic [63:0] LINE_ALIGN_MASK = ~((64'd1 << LINE_OFF_W) - 64'd1);

endpackage

// File: rtl/mem_arbiter_l1_if.sv
// Bundle of the icache, dcache and main-memory handshake/bus signals around the arbiter.
// master: arbiter view (takes cache requests and memory responses, drives the rest).
// slave : environment view (caches plus memory model/controller).
interface mem_arbiter_l1_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
);

   // icache side
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_valid;
   logic [LINE_W-1:0] i_data;

   // dcache side
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic              d_valid;
   logic [LINE_W-1:0] d_rdata;

   // main-memory side
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_address;
   logic [LINE_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_valid;

   modport master (
      input  i_req, i_addr,
      input  d_req, d_we, d_addr, d_wdata,
      input  mem_rdata, mem_valid,
      output i_valid, i_data,
      output d_valid, d_rdata,
      output mem_req, mem_we, mem_address, mem_wdata
   );

   modport slave (
      output i_req, i_addr,
      output d_req, d_we, d_addr, d_wdata,
      output mem_rdata, mem_valid,
      input  i_valid, i_data,
      input  d_valid, d_rdata,
      input  mem_req, mem_we, mem_address, mem_wdata
   );

endinterface

// File: rtl/mem_arbiter_l1_rr_arb2.sv
// Combinational two-way round-robin pick between icache and dcache requests.
// Ports: i_req, d_req, last_grant in; any_req (someone is asking) and winner out.
// Zero latency; a lone requester always wins, a tie goes to the side not granted last.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic   i_req,
   input  logic   d_req,
   input  grant_e last_grant,
   output logic   any_req,
   output grant_e winner
);

   always_comb begin
      any_req = i_req | d_req;
      winner  = GNT_I;
      if (i_req && d_req) begin
         winner = (last_grant == GNT_I) ? GNT_D : GNT_I;
      end else if (d_req) begin
         winner = GNT_D;
      end
   end

endmodule

// File: rtl/mem_arbiter_l1.sv
// Shares one line-wide main-memory port between the L1 icache and dcache, one transaction at a time.
// Ports: clk, rst (async, active-high); bus (mem_arbiter_l1_if.master); busy; timeout_err.
// Latency: mem_req 1 cycle after a request is seen, cache valid 1 cycle after mem_valid; DONE blocks 1 cycle.
// Optional: define MEM_ARB_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT_CYCLES cycles.
module mem_arbiter_l1
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int LINE_W         = 256,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic             clk,
   input  logic             rst,
   mem_arbiter_l1_if.master bus,
   output logic             busy,
   output logic             timeout_err
);

   localparam logic [ADDR_W-1:0] ADDR_MASK = LINE_ALIGN_MASK[ADDR_W-1:0];

   // the timeout compare below counts to TIMEOUT_CYCLES-1
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("mem_arbiter_l1: TIMEOUT_CYCLES must be at least 1");
   end

   state_e            state, state_n;
   // last_grant is written at grant time, so during WAIT/DONE it is also the current owner
   grant_e            last_grant, last_grant_n;
   grant_e            pick;
   logic              pick_vld;

   logic              mem_req_n;
   logic              mem_we_n;
   logic [ADDR_W-1:0] mem_address_n;
   logic [LINE_W-1:0] mem_wdata_n;
   logic              i_valid_n;
   logic [LINE_W-1:0] i_data_n;
   logic              d_valid_n;
   logic [LINE_W-1:0] d_rdata_n;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]  wait_cnt, wait_cnt_n;
   logic              timeout_n;
`endif

   rr_arb2 u_rr_arb2 (
      .i_req      (bus.i_req),
      .d_req      (bus.d_req),
      .last_grant (last_grant),
      .any_req    (pick_vld),
      .winner     (pick)
   );

   assign busy = (state != IDLE);

   // next-state and next-output logic; every register holds unless told otherwise
   always_comb begin
      state_n       = state;
      last_grant_n  = last_grant;
      mem_req_n     = bus.mem_req;
      mem_we_n      = bus.mem_we;
      mem_address_n = bus.mem_address;
      mem_wdata_n   = bus.mem_wdata;
      i_valid_n     = 1'b0;
      i_data_n      = bus.i_data;
      d_valid_n     = 1'b0;
      d_rdata_n     = bus.d_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
      wait_cnt_n    = wait_cnt;
      timeout_n     = 1'b0;
`endif

      case (state)
         IDLE: begin
            // mem_valid is ignored here: nothing is outstanding
            if (pick_vld) begin
               state_n      = WAIT;
               last_grant_n = pick;
               mem_req_n    = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
               wait_cnt_n   = '0;
`endif
               if (pick == GNT_I) begin
                  mem_we_n      = 1'b0;
                  mem_address_n = bus.i_addr & ADDR_MASK;
                  mem_wdata_n   = '0;
               end else begin
                  mem_we_n      = bus.d_we;
                  mem_address_n = bus.d_addr & ADDR_MASK;
                  mem_wdata_n   = bus.d_wdata;
               end
            end
         end

         WAIT: begin
            // grant and address are latched; request-side changes have no effect here
            if (bus.mem_valid) begin
               state_n   = DONE;
               mem_req_n = 1'b0;
               mem_we_n  = 1'b0;
               if (last_grant == GNT_I) begin
                  i_valid_n = 1'b1;
                  i_data_n  = bus.mem_rdata;
               end else begin
                  d_valid_n = 1'b1;
                  // a write-back only gets an acknowledge; the read line is left alone
                  if (!bus.mem_we) begin
                     d_rdata_n = bus.mem_rdata;
                  end
               end
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               // this is the last allowed WAIT cycle: abort with an all-zero line
               state_n   = DONE;
               mem_req_n = 1'b0;
               mem_we_n  = 1'b0;
               timeout_n = 1'b1;
               if (last_grant == GNT_I) begin
                  i_valid_n = 1'b1;
                  i_data_n  = '0;
               end else begin
                  d_valid_n = 1'b1;
                  d_rdata_n = '0;
               end
            end else begin
               wait_cnt_n = wait_cnt + 1'b1;
            end
`endif
         end

         DONE: begin
            // requests are not sampled here, giving the served cache a cycle to drop req
            state_n = IDLE;
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         last_grant      <= GNT_D;
         bus.mem_req     <= 1'b0;
         bus.mem_we      <= 1'b0;
         bus.mem_address <= '0;
         bus.mem_wdata   <= '0;
         bus.i_valid     <= 1'b0;
         bus.i_data      <= '0;
         bus.d_valid     <= 1'b0;
         bus.d_rdata     <= '0;
      end else begin
         state           <= state_n;
         last_grant      <= last_grant_n;
         bus.mem_req     <= mem_req_n;
         bus.mem_we      <= mem_we_n;
         bus.mem_address <= mem_address_n;
         bus.mem_wdata   <= mem_wdata_n;
         bus.i_valid     <= i_valid_n;
         bus.i_data      <= i_data_n;
         bus.d_valid     <= d_valid_n;
         bus.d_rdata     <= d_rdata_n;
      end
   end

`ifdef MEM_ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         wait_cnt    <= wait_cnt_n;
         timeout_err <= timeout_n;
      end
   end
`else
   assign timeout_err = 1'b0;
`endif

endmodule
